// File: rtl/fb_write_scheduler.sv
// Purpose: arbitrates frame-buffer write port between a host write FIFO and a full-screen clear sweep.
// Latency: a host write is issued no earlier than the cycle after its push; fb outputs are combinational from state and slot.
// Backpressure: o_wr_ready drops when the FIFO is full or a clear is pending/running; writes wait for a safe slot.
// Optional macro FB_ACTIVE_WRITE_EN: also treat active-video cycles without a pixel-advance strobe as safe slots.
module fb_write_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_WORDS   = 4800
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [12:0]                   i_wr_addr,
    input  logic [7:0]                    i_wr_data,
    input  logic                          i_clear_req,
    input  logic [7:0]                    i_clear_data,
    output logic                          o_clear_busy,
    input  logic                          i_blank,
    input  logic                          i_fetch_next_pixel,
    output logic                          o_fb_update,
    output logic [12:0]                   o_fb_addr,
    output logic [7:0]                    o_fb_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [12:0]   LAST_ADDR = 13'(FB_WORDS - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [12:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] level;

    state_t        state;
    logic          clear_pending;
    logic [12:0]   clear_addr;
    logic [7:0]    fill_byte;
    logic          clear_busy;

    logic          slot;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          clear_wr;
    logic          clear_accept;

`ifdef FB_ACTIVE_WRITE_EN
    assign slot = i_blank | ~i_fetch_next_pixel;
`else
    // Pixel strobe only matters when active-video writes are allowed.
    logic unused_fetch;
    assign unused_fetch = i_fetch_next_pixel;
    assign slot = i_blank;
`endif

    assign empty        = (level == '0);
    assign full         = (level == FULL_LVL);
    assign o_wr_ready   = !full && !clear_pending && (state != CLEAR);
    assign push         = i_wr_valid && o_wr_ready;
    // Head is written only from IDLE, so pops are naturally suppressed while sweeping.
    assign pop          = (state == IDLE) && slot && !empty;
    assign clear_wr     = (state == CLEAR) && slot;
    assign clear_accept = i_clear_req && !clear_pending && (state != CLEAR);

    assign o_fb_update  = pop | clear_wr;
    assign o_clear_busy = clear_busy;
    assign o_fifo_level = level;

    // Select write address/data; idle bus is held at zero.
    always_comb begin
        o_fb_addr = '0;
        o_fb_data = '0;
        if (clear_wr) begin
            o_fb_addr = clear_addr;
            o_fb_data = fill_byte;
        end else if (pop) begin
            o_fb_addr = fifo_addr[rd_ptr];
            o_fb_data = fifo_data[rd_ptr];
        end
    end

    // FIFO storage: payload only, no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_wr_addr;
            fifo_data[wr_ptr] <= i_wr_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Clear sequencer: latch request, wait for FIFO to drain, then sweep every address in safe slots.
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            clear_addr    <= '0;
            fill_byte     <= '0;
            clear_busy    <= 1'b0;
        end else begin
            if (clear_accept) begin
                clear_pending <= 1'b1;
                fill_byte     <= i_clear_data;
                clear_busy    <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clear_pending && empty && slot) begin
                        state      <= CLEAR;
                        clear_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (slot) begin
                        if (clear_addr == LAST_ADDR) begin
                            state         <= IDLE;
                            clear_pending <= 1'b0;
                            clear_busy    <= 1'b0;
                            clear_addr    <= '0;
                        end else begin
                            clear_addr <= clear_addr + 13'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
